syn_fgyrus_pcm_fetch: RTL

Fetch stage at the front of the fgyrus FFT engine. It sits directly downstream of the acortex PCM buffers. When acortex signals that one half of the 128-entry left/right PCM memories is full, this block reads that 64-sample frame from both channel memories and streams it, one stereo pair per beat, to the FFT input under valid/ready backpressure. It runs on the fgyrus 100 MHz clock domain.

---
 rtl/syn_fgyrus_pkg.sv | 32 +++
 rtl/syn_fgyrus_pcm_fifo.sv | 56 +++++
 rtl/syn_fgyrus_pcm_fetch.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/syn_fgyrus_pkg.sv
// Shared types and constants for the fgyrus PCM fetch stage.
// Sample pair layout, frame length and fetch FSM encoding.
package syn_fgyrus_pkg;

  localparam int PCM_DATA_W    = 32;
  localparam int PCM_ADDR_W    = 7;
  localparam int PCM_IDX_W     = 6;
  localparam int PCM_FRAME_LEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } pcm_fetch_st_t;

  typedef struct packed {
    logic [PCM_DATA_W-1:0] lchnnl;
    logic [PCM_DATA_W-1:0] rchnnl;
    logic [PCM_IDX_W-1:0]  idx;
  } pcm_smpl_t;

  // Average of L and R, floor-rounded, no intermediate overflow.
  function automatic logic [PCM_DATA_W-1:0] pcm_mono(
    input logic [PCM_DATA_W-1:0] l,
    input logic [PCM_DATA_W-1:0] r
  );
    logic [PCM_DATA_W:0] sum;
    sum = {l[PCM_DATA_W-1], l} + {r[PCM_DATA_W-1], r};
    return sum[PCM_DATA_W:1];
  endfunction

endpackage

// File: rtl/syn_fgyrus_pcm_fifo.sv
// Small synchronous FIFO of PCM sample pairs with occupancy count.
// The head entry is presented combinationally from storage.
module syn_fgyrus_pcm_fifo
  import syn_fgyrus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_ir,
  input  logic          rst_ih,
  input  logic          push_i,
  input  pcm_smpl_t     wdata_i,
  input  logic          pop_i,
  output pcm_smpl_t     rdata_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pcm_smpl_t     mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= nxt(wr_q);
      end
      if (pop_ok) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/syn_fgyrus_pcm_fetch.sv
// fgyrus PCM fetch: streams 64-sample stereo frames from acortex buffers.
// Optional SYN_FGYRUS_PCM_FETCH_MONO_EN adds the smpl_mono output.
module syn_fgyrus_pcm_fetch
  import syn_fgyrus_pkg::*;
#(
  parameter int PCM_MEM_DATA_W = PCM_DATA_W,
  parameter int PCM_MEM_ADDR_W = PCM_ADDR_W,
  parameter int MEM_RD_DELAY   = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk_ir,
  input  logic                      rst_ih,
  input  logic [1:0]                pcm_data_rdy_oh,
  output logic [PCM_MEM_ADDR_W-1:0] mem_addr,
  output logic                      mem_rden,
  input  logic [PCM_MEM_DATA_W-1:0] lchnnl_rdata,
  input  logic [PCM_MEM_DATA_W-1:0] rchnnl_rdata,
  input  logic                      mem_rd_valid,
  output logic                      smpl_valid,
  input  logic                      smpl_ready,
  output logic [PCM_MEM_DATA_W-1:0] smpl_lchnnl,
  output logic [PCM_MEM_DATA_W-1:0] smpl_rchnnl,
  output logic [PCM_IDX_W-1:0]      smpl_idx,
  output logic                      smpl_sof,
  output logic                      smpl_eof,
  output logic [7:0]                overrun_cnt,
`ifdef SYN_FGYRUS_PCM_FETCH_MONO_EN
  output logic [PCM_MEM_DATA_W-1:0] smpl_mono,
`endif
  output logic                      busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PCM_IDX_W-1:0] LAST = PCM_IDX_W'(PCM_FRAME_LEN - 1);

  if (FIFO_DEPTH < MEM_RD_DELAY + 2 || MEM_RD_DELAY < 1 || MEM_RD_DELAY > 2)
  begin : g_bad_cfg
    $error("syn_fgyrus_pcm_fetch: bad MEM_RD_DELAY/FIFO_DEPTH");
  end

  pcm_fetch_st_t        st_q;
  logic                 half_q;
  logic [PCM_IDX_W-1:0] rd_cnt_q;
  logic [PCM_IDX_W-1:0] ret_idx_q;
  logic [CW-1:0]        out_q;
  logic [1:0]           pend_q;
  logic [1:0]           pend_d;
  logic [7:0]           ovr_q;
  logic [7:0]           ovr_d;
  logic [8:0]           ovr_sum;
  logic [1:0]           hit;

  logic          rd_ok;
  logic          rv_ok;
  logic          pop;
  logic          last_pop;
  logic          sel_go;
  logic          sel_half;
  logic          empty;
  logic [CW-1:0] occ;
  pcm_smpl_t     head;
  pcm_smpl_t     wdata;

  // Credit covers both buffered beats and reads still in flight.
  assign rd_ok = (st_q == FETCH) &&
                 ((CW + 1)'(occ) + (CW + 1)'(out_q) < (CW + 1)'(FIFO_DEPTH));
  assign rv_ok    = mem_rd_valid && (out_q != '0);
  assign pop      = smpl_valid && smpl_ready;
  assign last_pop = pop && (head.idx == LAST);
  assign sel_half = ~pend_q[0];
  assign sel_go   = (pend_q != 2'b00) &&
                    ((st_q == IDLE) || ((st_q == DRAIN) && last_pop));

  assign hit[0] = pcm_data_rdy_oh[0] & (pend_q[0] | (busy & ~half_q));
  assign hit[1] = pcm_data_rdy_oh[1] & (pend_q[1] | (busy &  half_q));
  assign ovr_sum = {1'b0, ovr_q} + {8'd0, hit[0]} + {8'd0, hit[1]};
  assign ovr_d   = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];

  always_comb begin
    pend_d = pend_q;
    if (sel_go) pend_d[sel_half] = 1'b0;
    pend_d = pend_d | pcm_data_rdy_oh;
  end

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      st_q      <= IDLE;
      half_q    <= 1'b0;
      rd_cnt_q  <= '0;
      ret_idx_q <= '0;
      out_q     <= '0;
      pend_q    <= 2'b00;
      ovr_q     <= 8'd0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      out_q  <= out_q + CW'(rd_ok) - CW'(rv_ok);
      if (rv_ok) ret_idx_q <= ret_idx_q + PCM_IDX_W'(1);
      if (rd_ok) rd_cnt_q <= rd_cnt_q + PCM_IDX_W'(1);
      unique case (st_q)
        IDLE: begin
          if (sel_go) begin
            st_q   <= FETCH;
            half_q <= sel_half;
          end
        end
        FETCH: begin
          if (rd_ok && rd_cnt_q == LAST) st_q <= DRAIN;
        end
        DRAIN: begin
          // A queued half chains straight on so busy stays high.
          if (last_pop) st_q <= sel_go ? FETCH : IDLE;
          if (sel_go) half_q <= sel_half;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign wdata = '{lchnnl: lchnnl_rdata,
                   rchnnl: rchnnl_rdata,
                   idx:    ret_idx_q};

  syn_fgyrus_pcm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_ir  (clk_ir),
    .rst_ih  (rst_ih),
    .push_i  (rv_ok),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (empty),
    .count_o (occ)
  );

  assign mem_addr    = PCM_MEM_ADDR_W'({half_q, rd_cnt_q});
  assign mem_rden    = rd_ok;
  assign busy        = (st_q != IDLE);
  assign overrun_cnt = ovr_q;
  assign smpl_valid  = ~empty;
  assign smpl_lchnnl = head.lchnnl;
  assign smpl_rchnnl = head.rchnnl;
  assign smpl_idx    = head.idx;
  assign smpl_sof    = smpl_valid && (head.idx == '0);
  assign smpl_eof    = smpl_valid && (head.idx == LAST);

`ifdef SYN_FGYRUS_PCM_FETCH_MONO_EN
  assign smpl_mono = pcm_mono(head.lchnnl, head.rchnnl);
`endif

endmodule
